// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-entry skid buffer
// for responses that arrive while decode stalls, and squashing of in-flight fetches on redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_stall,
    input  logic        EX_take_branch,
    input  logic [31:0] EX_target_pc,
    output logic        proc2Imem_req,
    output logic [31:0] proc2Imem_addr,
    input  logic        Imem2proc_vld,
    input  logic [31:0] Imem2proc_data,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_vld
);

    typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_e;

    state_e      state_q;
    logic [31:0] pc_q, req_addr_q;
    logic [31:0] buf_pc_q, buf_inst_q;
    logic [31:0] ifid_pc_q, ifid_inst_q;
    logic        ifid_vld_q;

    logic [31:0] tgt_aligned;
    logic [31:0] seq_pc;
    logic        unused_tgt_lsbs;

    assign tgt_aligned     = {EX_target_pc[31:2], 2'b00};
    assign seq_pc          = req_addr_q + 32'd4;
    assign unused_tgt_lsbs = ^EX_target_pc[1:0];

    // HOLD is the only state without a request in flight.
    assign proc2Imem_req  = !rst && (state_q != HOLD);
    assign proc2Imem_addr = req_addr_q;
    assign IF_ID_pc       = ifid_pc_q;
    assign IF_ID_inst     = ifid_inst_q;
    assign IF_ID_vld      = ifid_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            buf_pc_q    <= 32'd0;
            buf_inst_q  <= NOP_INST;
            ifid_pc_q   <= 32'd0;
            ifid_inst_q <= NOP_INST;
            ifid_vld_q  <= 1'b0;
        end else if (EX_take_branch) begin
            ifid_vld_q  <= 1'b0;
            ifid_inst_q <= NOP_INST;
            pc_q        <= tgt_aligned;
            // A request still in flight must be drained before the target can be fetched.
            if (state_q != HOLD && !Imem2proc_vld) begin
                state_q <= SQUASH;
            end else begin
                state_q    <= FETCH;
                req_addr_q <= tgt_aligned;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (Imem2proc_vld) begin
                        pc_q       <= seq_pc;
                        req_addr_q <= seq_pc;
                        if (ID_stall) begin
                            buf_pc_q   <= req_addr_q;
                            buf_inst_q <= Imem2proc_data;
                            state_q    <= HOLD;
                        end else begin
                            ifid_pc_q   <= req_addr_q;
                            ifid_inst_q <= Imem2proc_data;
                            ifid_vld_q  <= 1'b1;
                        end
                    end else if (!ID_stall) begin
                        ifid_vld_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!ID_stall) begin
                        ifid_pc_q   <= buf_pc_q;
                        ifid_inst_q <= buf_inst_q;
                        ifid_vld_q  <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                SQUASH: begin
                    if (Imem2proc_vld) begin
                        req_addr_q <= pc_q;
                        state_q    <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule
